// File: rtl/regfile_port_arbiter.sv
// Round-robin arbiter that shares the register-file write/SR1 port between
// the datapath (port 0) and the debug console (port 1). It also runs a
// clear sweep that zeroes every register, one register per cycle.
module regfile_port_arbiter #(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned ADDR_W = 3
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic [1:0]        req,
   input  logic [1:0]        we,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic [1:0]        ack,
   output logic [DATA_W-1:0] rdata,
   input  logic              clr_start,
   output logic              clr_busy,
   output logic              clr_done,
   output logic              rf_Load,
   output logic [ADDR_W-1:0] rf_DRIN,
   output logic [DATA_W-1:0] rf_DataIn,
   output logic [ADDR_W-1:0] rf_SR1in,
   input  logic [DATA_W-1:0] rf_SR1out
);

   localparam int unsigned NREGS = 2 ** ADDR_W;
   localparam int unsigned CNT_W = ADDR_W + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCESS,
      S_ACK,
      S_SWEEP
   } state_e;

   state_e              state_q;
   logic [1:0]          ack_q;
   logic [DATA_W-1:0]   rdata_q;
   logic                clr_done_q;
   logic                clr_pend_q;
   logic                last_gnt_q;
   logic                idx_q;
   logic [ADDR_W-1:0]   addr_q;
   logic                we_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [CNT_W-1:0]    cnt_q;

   logic                gnt_d;
   logic [CNT_W-1:0]    cnt_d;
   logic                sweep_last;

   // Winner selection: a lone requester wins; on a tie the port not granted last time wins.
   always_comb begin
      gnt_d      = req[1] & (~req[0] | ~last_gnt_q);
      cnt_d      = cnt_q + CNT_W'(1);
      sweep_last = (cnt_q == CNT_W'(NREGS - 1));
   end

   // Control FSM with latched command, registered ack/rdata/clr_done.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q    <= S_IDLE;
         ack_q      <= '0;
         rdata_q    <= '0;
         clr_done_q <= 1'b0;
         clr_pend_q <= 1'b0;
         last_gnt_q <= 1'b1;
         idx_q      <= 1'b0;
         addr_q     <= '0;
         we_q       <= 1'b0;
         wdata_q    <= '0;
         cnt_q      <= '0;
      end else begin
         ack_q      <= '0;
         clr_done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (clr_start || clr_pend_q) begin
                  clr_pend_q <= 1'b0;
                  cnt_q      <= '0;
                  state_q    <= S_SWEEP;
               end else if (req != 2'b00) begin
                  idx_q      <= gnt_d;
                  last_gnt_q <= gnt_d;
                  addr_q     <= gnt_d ? addr1 : addr0;
                  we_q       <= we[gnt_d];
                  wdata_q    <= gnt_d ? wdata1 : wdata0;
                  state_q    <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               if (!we_q) begin
                  rdata_q <= rf_SR1out;
               end
               ack_q[idx_q] <= 1'b1;
               if (clr_start) begin
                  clr_pend_q <= 1'b1;
               end
               state_q <= S_ACK;
            end
            S_ACK: begin
               if (clr_start) begin
                  clr_pend_q <= 1'b1;
               end
               state_q <= S_IDLE;
            end
            S_SWEEP: begin
               cnt_q <= cnt_d;
               if (sweep_last) begin
                  clr_done_q <= 1'b1;
                  state_q    <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Register-file drive decoded from the current state and the latched command.
   always_comb begin
      rf_Load   = 1'b0;
      rf_DRIN   = '0;
      rf_DataIn = '0;
      rf_SR1in  = '0;
      case (state_q)
         S_ACCESS: begin
            rf_Load   = we_q;
            rf_DRIN   = addr_q;
            rf_DataIn = wdata_q;
            rf_SR1in  = addr_q;
         end
         S_SWEEP: begin
            rf_Load = 1'b1;
            rf_DRIN = cnt_q[ADDR_W-1:0];
         end
         default: ;
      endcase
   end

   assign ack      = ack_q;
   assign rdata    = rdata_q;
   assign clr_done = clr_done_q;
   assign clr_busy = (state_q == S_SWEEP);

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed bench for regfile_port_arbiter with a behavioural 8x16 register file.
module tb_regfile_port_arbiter;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [1:0]  req;
   logic [1:0]  we;
   logic [2:0]  addr0, addr1;
   logic [15:0] wdata0, wdata1;
   logic [1:0]  ack;
   logic [15:0] rdata;
   logic        clr_start;
   logic        clr_busy, clr_done;
   logic        rf_Load;
   logic [2:0]  rf_DRIN, rf_SR1in;
   logic [15:0] rf_DataIn, rf_SR1out;

   logic [15:0] rf [8];

   int checks   = 0;
   int failures = 0;

   regfile_port_arbiter #(.DATA_W(16), .ADDR_W(3)) dut (
      .Clk(Clk), .Reset(Reset), .req(req), .we(we),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .ack(ack), .rdata(rdata), .clr_start(clr_start),
      .clr_busy(clr_busy), .clr_done(clr_done),
      .rf_Load(rf_Load), .rf_DRIN(rf_DRIN), .rf_DataIn(rf_DataIn),
      .rf_SR1in(rf_SR1in), .rf_SR1out(rf_SR1out)
   );

   always #5 Clk = ~Clk;

   // Register file model: synchronous write, combinational SR1 read.
   always @(posedge Clk) begin
      if (rf_Load) rf[rf_DRIN] <= rf_DataIn;
   end
   assign rf_SR1out = rf[rf_SR1in];

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic do_reset();
      Reset = 1'b1; req = '0; we = '0; addr0 = '0; addr1 = '0;
      wdata0 = '0; wdata1 = '0; clr_start = 1'b0;
      tick(); tick();
      Reset = 1'b0;
   endtask

   // Drives one access from IDLE, waits (bounded) for its ack, then returns in IDLE.
   task automatic access(input int port, input logic wr, input logic [2:0] a,
                         input logic [15:0] d, output logic got,
                         output logic [15:0] rd, output int lat);
      got = 1'b0; rd = '0; lat = 0;
      if (port == 0) begin addr0 = a; wdata0 = d; we[0] = wr; req[0] = 1'b1; end
      else           begin addr1 = a; wdata1 = d; we[1] = wr; req[1] = 1'b1; end
      for (int i = 1; i <= 20 && !got; i++) begin
         tick();
         if (ack[port]) begin got = 1'b1; rd = rdata; lat = i; end
      end
      req = 2'b00;
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (ack !== 2'b00) begin failures++; $display("FAIL reset_ack got=%b exp=00", ack); end
      checks++; if (rdata !== 16'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0000", rdata); end
      checks++; if (clr_busy !== 1'b0 || clr_done !== 1'b0) begin failures++;
         $display("FAIL reset_clr busy=%b done=%b exp=0/0", clr_busy, clr_done); end
      checks++; if (rf_Load !== 1'b0 || rf_DRIN !== 3'd0 || rf_DataIn !== 16'h0 || rf_SR1in !== 3'd0) begin
         failures++; $display("FAIL reset_rf load=%b drin=%0d din=%h sr1=%0d exp=0", rf_Load, rf_DRIN, rf_DataIn, rf_SR1in); end
   endtask

   task automatic test_write();
      req = 2'b01; we = 2'b01; addr0 = 3'd3; wdata0 = 16'hBEEF;
      tick();
      checks++; if (rf_Load !== 1'b1 || rf_DRIN !== 3'd3 || rf_DataIn !== 16'hBEEF) begin failures++;
         $display("FAIL write_access load=%b drin=%0d din=%h exp=1/3/beef", rf_Load, rf_DRIN, rf_DataIn); end
      checks++; if (ack !== 2'b00) begin failures++; $display("FAIL write_early_ack got=%b exp=00", ack); end
      tick();
      checks++; if (ack !== 2'b01) begin failures++; $display("FAIL write_ack got=%b exp=01", ack); end
      checks++; if (rf_Load !== 1'b0) begin failures++; $display("FAIL write_ack_load got=%b exp=0", rf_Load); end
      req = 2'b00;
      tick();
      checks++; if (ack !== 2'b00) begin failures++; $display("FAIL write_ack_clear got=%b exp=00", ack); end
      checks++; if (rf[3] !== 16'hBEEF) begin failures++; $display("FAIL write_rf3 got=%h exp=beef", rf[3]); end
   endtask

   task automatic test_read();
      logic got; logic [15:0] rd; int lat;
      we = 2'b00;
      access(0, 1'b0, 3'd3, 16'h0, got, rd, lat);
      checks++; if (!got || lat != 2) begin failures++; $display("FAIL read_latency got=%0b lat=%0d exp=1/2", got, lat); end
      checks++; if (rd !== 16'hBEEF) begin failures++; $display("FAIL read_data got=%h exp=beef", rd); end
      checks++; if (rdata !== 16'hBEEF) begin failures++; $display("FAIL read_hold got=%h exp=beef", rdata); end
   endtask

   task automatic test_round_robin();
      logic [1:0] exp_ack;
      logic [2:0] exp_dr;
      do_reset();
      req = 2'b11; we = 2'b11; addr0 = 3'd1; wdata0 = 16'hAAAA; addr1 = 3'd2; wdata1 = 16'h5555;
      for (int k = 1; k <= 11; k++) begin
         tick();
         exp_ack = 2'b00;
         if (k % 3 == 2) exp_ack = (((k / 3) % 2) == 0) ? 2'b01 : 2'b10;
         checks++; if (ack !== exp_ack) begin failures++;
            $display("FAIL rr_ack cycle=%0d got=%b exp=%b", k, ack, exp_ack); end
         if (k % 3 == 1) begin
            exp_dr = (((k / 3) % 2) == 0) ? 3'd1 : 3'd2;
            checks++; if (rf_Load !== 1'b1 || rf_DRIN !== exp_dr) begin failures++;
               $display("FAIL rr_drin cycle=%0d load=%b got=%0d exp=%0d", k, rf_Load, rf_DRIN, exp_dr); end
         end
      end
      req = 2'b00;
      tick();
      checks++; if (rf[1] !== 16'hAAAA || rf[2] !== 16'h5555) begin failures++;
         $display("FAIL rr_rf r1=%h r2=%h exp=aaaa/5555", rf[1], rf[2]); end
   endtask

   task automatic test_clear();
      logic got; logic [15:0] rd; int lat;
      for (int r = 0; r < 8; r++) begin
         access(0, 1'b1, 3'(r), 16'(r + 1), got, rd, lat);
         checks++; if (!got || rf[r] !== 16'(r + 1)) begin failures++;
            $display("FAIL clr_prefill r=%0d got=%0b val=%h exp=%h", r, got, rf[r], 16'(r + 1)); end
      end
      clr_start = 1'b1;
      tick();
      clr_start = 1'b0;
      for (int k = 0; k < 8; k++) begin
         checks++; if (clr_busy !== 1'b1 || rf_Load !== 1'b1 || rf_DRIN !== 3'(k) ||
                       rf_DataIn !== 16'h0 || clr_done !== 1'b0) begin failures++;
            $display("FAIL clr_sweep k=%0d busy=%b load=%b drin=%0d din=%h done=%b exp=1/1/%0d/0/0",
                     k, clr_busy, rf_Load, rf_DRIN, rf_DataIn, clr_done, k); end
         tick();
      end
      checks++; if (clr_busy !== 1'b0 || clr_done !== 1'b1 || rf_Load !== 1'b0) begin failures++;
         $display("FAIL clr_done_pulse busy=%b done=%b load=%b exp=0/1/0", clr_busy, clr_done, rf_Load); end
      tick();
      checks++; if (clr_done !== 1'b0) begin failures++; $display("FAIL clr_done_clear got=%b exp=0", clr_done); end
      for (int r = 0; r < 8; r++) begin
         access(0, 1'b0, 3'(r), 16'h0, got, rd, lat);
         checks++; if (!got || rd !== 16'h0) begin failures++;
            $display("FAIL clr_readback r=%0d got=%0b val=%h exp=0000", r, got, rd); end
      end
   endtask

   task automatic test_clr_in_access();
      logic got; logic [15:0] rd; int lat;
      logic seen;
      req = 2'b10; we = 2'b10; addr1 = 3'd6; wdata1 = 16'h1234;
      tick();
      checks++; if (rf_Load !== 1'b1 || rf_DRIN !== 3'd6) begin failures++;
         $display("FAIL cia_access load=%b drin=%0d exp=1/6", rf_Load, rf_DRIN); end
      clr_start = 1'b1;
      tick();
      clr_start = 1'b0;
      checks++; if (ack !== 2'b10) begin failures++; $display("FAIL cia_ack got=%b exp=10", ack); end
      req = 2'b00;
      tick();
      checks++; if (clr_busy !== 1'b0 || ack !== 2'b00) begin failures++;
         $display("FAIL cia_idle busy=%b ack=%b exp=0/00", clr_busy, ack); end
      tick();
      checks++; if (clr_busy !== 1'b1) begin failures++; $display("FAIL cia_sweep_start got=%b exp=1", clr_busy); end
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         tick();
         if (clr_done) seen = 1'b1;
      end
      checks++; if (!seen) begin failures++; $display("FAIL cia_done_timeout got=0 exp=1"); end
      access(0, 1'b0, 3'd6, 16'h0, got, rd, lat);
      checks++; if (!got || rd !== 16'h0) begin failures++;
         $display("FAIL cia_r6 got=%0b val=%h exp=0000", got, rd); end
   endtask

   task automatic test_reset_mid_sweep();
      logic got; logic [15:0] rd; int lat;
      access(0, 1'b1, 3'd5, 16'h0055, got, rd, lat);
      access(0, 1'b1, 3'd6, 16'h0066, got, rd, lat);
      access(0, 1'b1, 3'd7, 16'h0077, got, rd, lat);
      clr_start = 1'b1;
      tick();
      clr_start = 1'b0;
      tick(); tick(); tick(); tick();
      checks++; if (clr_busy !== 1'b1 || rf_DRIN !== 3'd4) begin failures++;
         $display("FAIL rms_cnt4 busy=%b drin=%0d exp=1/4", clr_busy, rf_DRIN); end
      Reset = 1'b1;
      tick();
      checks++; if (rf_Load !== 1'b0 || clr_busy !== 1'b0 || clr_done !== 1'b0) begin failures++;
         $display("FAIL rms_abort load=%b busy=%b done=%b exp=0/0/0", rf_Load, clr_busy, clr_done); end
      Reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++; if (clr_done !== 1'b0 || rf_Load !== 1'b0) begin failures++;
            $display("FAIL rms_quiet cycle=%0d done=%b load=%b exp=0/0", i, clr_done, rf_Load); end
      end
      for (int r = 5; r < 8; r++) begin
         access(0, 1'b0, 3'(r), 16'h0, got, rd, lat);
         checks++; if (!got || rd !== 16'(8'h55 + 8'h11 * (r - 5))) begin failures++;
            $display("FAIL rms_keep r=%0d got=%0b val=%h exp=%h", r, got, rd, 16'(8'h55 + 8'h11 * (r - 5))); end
      end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_round_robin();
      test_clear();
      test_clr_in_access();
      test_reset_mid_sweep();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "watchdog");
   end

endmodule
